lcd_readback: RTL

//  Read side of the 16x2 HD44780 character-LCD bus (RW=1 cycles). On host request, returns either

---
 rtl/lcd_readback.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_readback.sv
// lcd_readback: read side of a 16x2 HD44780 character-LCD bus (RW=1 cycles).
// Returns either {BF, AC} or the character at a display index (0-31).
// Owns LCD_DATA/RS/RW/E only while oBUSY=1; an external mux arbitrates the bus.
// Optional feature: define LCD_BF_POLL_EN to replace the fixed post-address wait
// with busy-flag polling bounded by a T_TMO timeout (sets oERR on expiry).
module lcd_readback #(
  parameter int unsigned T_AS  = 2,
  parameter int unsigned T_EH  = 25,
  parameter int unsigned T_EL  = 25,
`ifdef LCD_BF_POLL_EN
  parameter int unsigned T_TMO = 100000,
`endif
  parameter int unsigned T_CMD = 2000
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic       iREQ,
  input  logic       iOP,
  input  logic [4:0] iINDEX,
  output logic       oBUSY,
  output logic       oVALID,
  output logic [7:0] oDATA,
  output logic       oBF,
  output logic       oERR,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_E
);

  localparam logic [16:0] CntAs  = 17'(T_AS - 1);
  localparam logic [16:0] CntEh  = 17'(T_EH - 1);
  localparam logic [16:0] CntEl  = 17'(T_EL - 1);
`ifdef LCD_BF_POLL_EN
  localparam logic [16:0] CntTmo = 17'(T_TMO - 1);
`else
  localparam logic [16:0] CntCmd = 17'(T_CMD - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
`ifdef LCD_BF_POLL_EN
    StPoll,
`else
    StWait,
`endif
    StRd,
    StDone
  } state_e;

  typedef enum logic [1:0] {PhSetup, PhHigh, PhLow} phase_e;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [16:0] cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  sample_q, sample_d;
  logic [7:0]  data_q, data_d;
  logic        bf_q, bf_d;
  logic        e_q, e_d, rs_q, rs_d, rw_q, rw_d, drive_q, drive_d;
  logic        bus_st, bus_nxt, phase_end;
`ifdef LCD_BF_POLL_EN
  logic [16:0] tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  // Write data (set-DDRAM-address command) is only driven during the address phase.
  assign LCD_DATA = drive_q ? {1'b1, addr_q} : 8'hzz;
  assign LCD_E    = e_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = rw_q;
  assign oBUSY    = (state_q != StIdle) && (state_q != StDone);
  assign oVALID   = (state_q == StDone);
  assign oDATA    = data_q;
  assign oBF      = bf_q;
`ifdef LCD_BF_POLL_EN
  assign oERR     = err_q;
`else
  assign oERR     = 1'b0;
`endif

  // Next-state: transaction sequencing plus the SETUP/EHIGH/ELOW strobe sub-sequence.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - 17'd1 : '0;
    op_d      = op_q;
    addr_d    = addr_q;
    sample_d  = sample_q;
    data_d    = data_q;
    bf_d      = bf_q;
    phase_end = 1'b0;
`ifdef LCD_BF_POLL_EN
    tmo_d     = (tmo_q != '0) ? tmo_q - 17'd1 : '0;
    err_d     = err_q;
    bus_st    = (state_q == StAddr) || (state_q == StRd) || (state_q == StPoll);
`else
    bus_st    = (state_q == StAddr) || (state_q == StRd);
`endif

    if (bus_st) begin
      unique case (phase_q)
        PhSetup: if (cnt_q == '0) begin
          phase_d = PhHigh;
          cnt_d   = CntEh;
        end
        PhHigh: if (cnt_q == '0) begin
          // Read data is captured on the last cycle E is high.
          sample_d = LCD_DATA;
`ifdef LCD_BF_POLL_EN
          if (state_q == StPoll) bf_d = LCD_DATA[7];
`endif
          phase_d  = PhLow;
          cnt_d    = CntEl;
        end
        default: if (cnt_q == '0) phase_end = 1'b1;
      endcase
    end

    case (state_q)
      StIdle: if (iREQ) begin
        op_d    = iOP;
        addr_d  = {iINDEX[4], 2'b00, iINDEX[3:0]};
        state_d = StReq;
      end
      StReq: begin
        state_d = op_q ? StAddr : StRd;
        phase_d = PhSetup;
        cnt_d   = CntAs;
      end
      StAddr: if (phase_end) begin
`ifdef LCD_BF_POLL_EN
        state_d = StPoll;
        phase_d = PhSetup;
        cnt_d   = CntAs;
        tmo_d   = CntTmo;
`else
        state_d = StWait;
        cnt_d   = CntCmd;
`endif
      end
`ifdef LCD_BF_POLL_EN
      StPoll: begin
        if (phase_end && !sample_q[7]) begin
          state_d = StRd;
          phase_d = PhSetup;
          cnt_d   = CntAs;
        end else if (tmo_q == '0) begin
          state_d = StDone;
          data_d  = 8'h00;
          err_d   = 1'b1;
        end else if (phase_end) begin
          phase_d = PhSetup;
          cnt_d   = CntAs;
        end
      end
`else
      StWait: if (cnt_q == '0) begin
        state_d = StRd;
        phase_d = PhSetup;
        cnt_d   = CntAs;
      end
`endif
      StRd: if (phase_end) begin
        state_d = StDone;
        data_d  = sample_q;
        if (!op_q) bf_d = sample_q[7];
`ifdef LCD_BF_POLL_EN
        err_d   = 1'b0;
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Bus controls are registered from the next state so E never glitches.
`ifdef LCD_BF_POLL_EN
    bus_nxt = (state_d == StAddr) || (state_d == StRd) || (state_d == StPoll);
`else
    bus_nxt = (state_d == StAddr) || (state_d == StRd);
`endif
    e_d     = bus_nxt && (phase_d == PhHigh);
    rs_d    = (state_d == StRd) && op_q;
    rw_d    = (state_d != StAddr);
    drive_d = (state_d == StAddr);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iCLK_50MHZ) begin
    if (!iRST_N) begin
      state_q  <= StIdle;
      phase_q  <= PhSetup;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      addr_q   <= '0;
      sample_q <= '0;
      data_q   <= '0;
      bf_q     <= 1'b0;
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b1;
      drive_q  <= 1'b0;
`ifdef LCD_BF_POLL_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      data_q   <= data_d;
      bf_q     <= bf_d;
      e_q      <= e_d;
      rs_q     <= rs_d;
      rw_q     <= rw_d;
      drive_q  <= drive_d;
`ifdef LCD_BF_POLL_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

endmodule
